// File: rtl/mccu_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit with CP0 exception
// sequencing: state codes, instruction field constants, CP0 register numbers,
// exception codes and the select encodings driven towards the datapath/CP0.
package mccu_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_EXC = 3'd5
  } state_e;

  // primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_COP0  = 6'b010000;

  // R-type function codes
  localparam logic [5:0] FN_ADD     = 6'b100000;
  localparam logic [5:0] FN_SUB     = 6'b100010;
  localparam logic [5:0] FN_AND     = 6'b100100;
  localparam logic [5:0] FN_OR      = 6'b100101;
  localparam logic [5:0] FN_XOR     = 6'b100110;
  localparam logic [5:0] FN_SLL     = 6'b000000;
  localparam logic [5:0] FN_SRL     = 6'b000010;
  localparam logic [5:0] FN_SRA     = 6'b000011;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;
  localparam logic [5:0] FN_ERET    = 6'b011000;

  // CP0 sub-ops carried in rs
  localparam logic [4:0] RS_MFC0 = 5'b00000;
  localparam logic [4:0] RS_MTC0 = 5'b00100;
  localparam logic [4:0] RS_ERET = 5'b10000;

  // CP0 register numbers carried in rd
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  // cause codes
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  localparam logic [1:0] MFC0_GPR    = 2'b00;
  localparam logic [1:0] MFC0_STATUS = 2'b01;
  localparam logic [1:0] MFC0_CAUSE  = 2'b10;
  localparam logic [1:0] MFC0_EPC    = 2'b11;

  localparam logic [1:0] SELPC_NPC = 2'b00;
  localparam logic [1:0] SELPC_EPC = 2'b01;
  localparam logic [1:0] SELPC_VEC = 2'b10;

  localparam logic [1:0] STAOP_MTC0 = 2'd0;
  localparam logic [1:0] STAOP_PUSH = 2'd1;
  localparam logic [1:0] STAOP_POP  = 2'd2;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  localparam logic [1:0] ALUB_REG   = 2'b00;
  localparam logic [1:0] ALUB_FOUR  = 2'b01;
  localparam logic [1:0] ALUB_IMM   = 2'b10;
  localparam logic [1:0] ALUB_BROFF = 2'b11;

  localparam logic [1:0] PCS_NPC = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_JR  = 2'b10;
  localparam logic [1:0] PCS_JMP = 2'b11;

  // one-hot style decode of the instruction held in IR
  typedef struct packed {
    logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr, i_syscall;
    logic i_addi, i_andi, i_ori, i_xori, i_lui, i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
    logic i_mtc0, i_mfc0, i_eret, i_rsvd;
  } instr_t;

  // CP0 register number -> mfc0 read-mux select
  function automatic logic [1:0] mfc0_sel(input logic [4:0] rd);
    case (rd)
      CP0_STATUS: return MFC0_STATUS;
      CP0_CAUSE:  return MFC0_CAUSE;
      CP0_EPC:    return MFC0_EPC;
      default:    return MFC0_GPR;
    endcase
  endfunction

endpackage

// File: rtl/mccu_exc_if.sv
// Control-unit <-> datapath/CP0 bundle. The control unit uses the master
// modport (drives enables/selects), the datapath side uses slave.
interface mccu_exc_if #(
  parameter int NUM_IRQ = 4,
  parameter int IRQ_IDW = 2
);
  logic [5:0]         op, func;
  logic [4:0]         rs, rd;
  logic               z, v, mem_ready;
  logic [NUM_IRQ-1:0] intr;
  logic [NUM_IRQ:0]   sta;

  logic               wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, alusrca, jal, sext;
  logic [3:0]         aluc;
  logic [1:0]         alusrcb, pcsource;
  logic               inta, exc;
  logic [4:0]         exccode;
  logic [IRQ_IDW-1:0] irq_id;
  logic               wsta, wcau, wepc;
  logic [1:0]         sta_op;
  logic               epcsrc, mtc0;
  logic [1:0]         mfc0, selpc;
  logic [2:0]         state;

  modport master (
    input  op, func, rs, rd, z, v, mem_ready, intr, sta,
    output wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, alusrca, jal, sext,
           aluc, alusrcb, pcsource, inta, exc, exccode, irq_id, wsta, wcau, wepc,
           sta_op, epcsrc, mtc0, mfc0, selpc, state
  );

  modport slave (
    output op, func, rs, rd, z, v, mem_ready, intr, sta,
    input  wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, alusrca, jal, sext,
           aluc, alusrcb, pcsource, inta, exc, exccode, irq_id, wsta, wcau, wepc,
           sta_op, epcsrc, mtc0, mfc0, selpc, state
  );
endinterface

// File: rtl/mccu_irq_arb.sv
// Interrupt arbiter: applies per-line mask and global enable from the CP0
// status word, picks the lowest-index pending line.
module mccu_irq_arb #(
  parameter int NUM_IRQ = 4,
  parameter int IRQ_IDW = 2
) (
  input  logic [NUM_IRQ-1:0] intr,
  input  logic [NUM_IRQ:0]   sta,
  output logic               take,
  output logic [IRQ_IDW-1:0] irq_id
);

  logic [NUM_IRQ-1:0] pending;

  // mask, global enable and lowest-index priority encode
  always_comb begin
    pending = intr & sta[NUM_IRQ:1];
    take    = sta[0] & (|pending);
    irq_id  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) irq_id = IRQ_IDW'(i);
    end
  end

endmodule

// File: rtl/mccu_exc.sv
// Multi-cycle MIPS control unit with CP0 exception/interrupt sequencing.
// Controls are combinational from the state register and the IR fields.
// Build option: MCCU_OVF_TRAP_EN enables the arithmetic overflow trap;
// without it v is ignored and add/sub/addi always write back.
module mccu_exc
  import mccu_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int IRQ_IDW = 2
) (
  input logic        clock,
  input logic        reset,
  mccu_exc_if.master bus
);

  state_e             state_q, state_d;
  logic [IRQ_IDW-1:0] irq_id_q, irq_id_d;
  logic [4:0]         exccode_q, exccode_d;
  logic               epcsrc_q, epcsrc_d;

  instr_t             dec;
  logic               irq_take;
  logic [IRQ_IDW-1:0] irq_win;
  logic               done;       // instruction retires this cycle
  logic               sync_exc;
  logic [4:0]         sync_code;

  mccu_irq_arb #(.NUM_IRQ(NUM_IRQ), .IRQ_IDW(IRQ_IDW)) u_irq_arb (
    .intr   (bus.intr),
    .sta    (bus.sta),
    .take   (irq_take),
    .irq_id (irq_win)
  );

`ifndef MCCU_OVF_TRAP_EN
  logic unused_v;
  assign unused_v = bus.v;
`endif

  // decode the instruction currently held in IR
  always_comb begin
    dec = '0;
    if (bus.op == OP_RTYPE) begin
      case (bus.func)
        FN_ADD:     dec.i_add     = 1'b1;
        FN_SUB:     dec.i_sub     = 1'b1;
        FN_AND:     dec.i_and     = 1'b1;
        FN_OR:      dec.i_or      = 1'b1;
        FN_XOR:     dec.i_xor     = 1'b1;
        FN_SLL:     dec.i_sll     = 1'b1;
        FN_SRL:     dec.i_srl     = 1'b1;
        FN_SRA:     dec.i_sra     = 1'b1;
        FN_JR:      dec.i_jr      = 1'b1;
        FN_SYSCALL: dec.i_syscall = 1'b1;
        default:    dec.i_rsvd    = 1'b1;
      endcase
    end else if (bus.op == OP_COP0) begin
      if (bus.rs == RS_MTC0)                            dec.i_mtc0 = 1'b1;
      else if (bus.rs == RS_MFC0)                       dec.i_mfc0 = 1'b1;
      else if (bus.rs == RS_ERET && bus.func == FN_ERET) dec.i_eret = 1'b1;
      else                                              dec.i_rsvd = 1'b1;
    end else begin
      case (bus.op)
        OP_ADDI: dec.i_addi = 1'b1;
        OP_ANDI: dec.i_andi = 1'b1;
        OP_ORI:  dec.i_ori  = 1'b1;
        OP_XORI: dec.i_xori = 1'b1;
        OP_LUI:  dec.i_lui  = 1'b1;
        OP_LW:   dec.i_lw   = 1'b1;
        OP_SW:   dec.i_sw   = 1'b1;
        OP_BEQ:  dec.i_beq  = 1'b1;
        OP_BNE:  dec.i_bne  = 1'b1;
        OP_J:    dec.i_j    = 1'b1;
        OP_JAL:  dec.i_jal  = 1'b1;
        default: dec.i_rsvd = 1'b1;
      endcase
    end
  end

  // next state, cause latches and per-state datapath/CP0 controls
  always_comb begin
    state_d   = S_IF;
    irq_id_d  = irq_id_q;
    exccode_d = exccode_q;
    epcsrc_d  = epcsrc_q;
    done      = 1'b0;
    sync_exc  = 1'b0;
    sync_code = EXC_RI;

    bus.wpc      = 1'b0;
    bus.wir      = 1'b0;
    bus.wmem     = 1'b0;
    bus.wreg     = 1'b0;
    bus.iord     = 1'b0;
    bus.regrt    = 1'b0;
    bus.m2reg    = 1'b0;
    bus.shift    = 1'b0;
    bus.alusrca  = 1'b0;
    bus.jal      = 1'b0;
    bus.sext     = 1'b1;
    bus.aluc     = ALU_ADD;
    bus.alusrcb  = ALUB_REG;
    bus.pcsource = PCS_NPC;
    bus.inta     = 1'b0;
    bus.exc      = 1'b0;
    bus.wsta     = 1'b0;
    bus.wcau     = 1'b0;
    bus.wepc     = 1'b0;
    bus.sta_op   = STAOP_MTC0;
    bus.mtc0     = 1'b0;
    bus.mfc0     = MFC0_GPR;
    bus.selpc    = SELPC_NPC;

    case (state_q)
      S_IF: begin
        if (bus.mem_ready) begin
          bus.wpc     = 1'b1;
          bus.wir     = 1'b1;
          bus.alusrca = 1'b1;
          bus.alusrcb = ALUB_FOUR;
          state_d     = S_ID;
        end
      end

      S_ID: begin
        if (dec.i_j) begin
          bus.pcsource = PCS_JMP;
          bus.wpc      = 1'b1;
          done         = 1'b1;
        end else if (dec.i_jal) begin
          bus.pcsource = PCS_JMP;
          bus.wpc      = 1'b1;
          bus.jal      = 1'b1;
          bus.wreg     = 1'b1;
          done         = 1'b1;
        end else if (dec.i_jr) begin
          bus.pcsource = PCS_JR;
          bus.wpc      = 1'b1;
          done         = 1'b1;
        end else if (dec.i_eret) begin
          bus.selpc  = SELPC_EPC;
          bus.wpc    = 1'b1;
          bus.wsta   = 1'b1;
          bus.sta_op = STAOP_POP;
          done       = 1'b1;
        end else if (dec.i_mtc0) begin
          bus.mtc0 = 1'b1;
          bus.wsta = (bus.rd == CP0_STATUS);
          bus.wcau = (bus.rd == CP0_CAUSE);
          bus.wepc = (bus.rd == CP0_EPC);
          done     = 1'b1;
        end else if (dec.i_mfc0) begin
          state_d = S_WB;
        end else if (dec.i_syscall) begin
          sync_exc  = 1'b1;
          sync_code = EXC_SYS;
        end else if (dec.i_rsvd) begin
          sync_exc  = 1'b1;
          sync_code = EXC_RI;
        end else begin
          // precompute branch target while the register file is read
          bus.alusrca = 1'b1;
          bus.alusrcb = ALUB_BROFF;
          state_d     = S_EXE;
        end
      end

      S_EXE: begin
        bus.shift   = dec.i_sll | dec.i_srl | dec.i_sra;
        bus.sext    = ~(dec.i_andi | dec.i_ori | dec.i_xori);
        bus.alusrcb = (bus.op == OP_RTYPE || dec.i_beq || dec.i_bne) ? ALUB_REG : ALUB_IMM;
        if (dec.i_sub || dec.i_beq || dec.i_bne) bus.aluc = ALU_SUB;
        else if (dec.i_and || dec.i_andi)        bus.aluc = ALU_AND;
        else if (dec.i_or  || dec.i_ori)         bus.aluc = ALU_OR;
        else if (dec.i_xor || dec.i_xori)        bus.aluc = ALU_XOR;
        else if (dec.i_lui)                      bus.aluc = ALU_LUI;
        else if (dec.i_sll)                      bus.aluc = ALU_SLL;
        else if (dec.i_srl)                      bus.aluc = ALU_SRL;
        else if (dec.i_sra)                      bus.aluc = ALU_SRA;
        else                                     bus.aluc = ALU_ADD;

        if (dec.i_beq || dec.i_bne) begin
          bus.pcsource = PCS_BR;
          bus.wpc      = dec.i_beq ? bus.z : ~bus.z;
          done         = 1'b1;
        end else if (dec.i_lw || dec.i_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
`ifdef MCCU_OVF_TRAP_EN
        if ((dec.i_add || dec.i_sub || dec.i_addi) && bus.v) begin
          sync_exc  = 1'b1;
          sync_code = EXC_OV;
        end
`endif
      end

      S_MEM: begin
        bus.iord = 1'b1;
        if (dec.i_sw) begin
          bus.wmem = bus.mem_ready;
          if (bus.mem_ready) done = 1'b1;
          else               state_d = S_MEM;
        end else begin
          state_d = bus.mem_ready ? S_WB : S_MEM;
        end
      end

      S_WB: begin
        bus.wreg = 1'b1;
        done     = 1'b1;
        if (dec.i_mfc0) begin
          bus.mfc0  = mfc0_sel(bus.rd);
          bus.regrt = 1'b1;
        end else begin
          bus.regrt = dec.i_addi | dec.i_andi | dec.i_ori | dec.i_xori | dec.i_lui | dec.i_lw;
          bus.m2reg = dec.i_lw;
        end
      end

      S_EXC: begin
        // IE is pushed to 0 here, so no interrupt is sampled on this exit
        bus.exc    = 1'b1;
        bus.wepc   = 1'b1;
        bus.wcau   = 1'b1;
        bus.wsta   = 1'b1;
        bus.sta_op = STAOP_PUSH;
        bus.selpc  = SELPC_VEC;
        bus.wpc    = 1'b1;
        bus.inta   = (exccode_q == EXC_INT);
        state_d    = S_IF;
      end

      default: state_d = S_IF;
    endcase

    // synchronous exceptions win; interrupts only at instruction retirement
    if (sync_exc) begin
      state_d   = S_EXC;
      exccode_d = sync_code;
      epcsrc_d  = 1'b1;
    end else if (done && irq_take) begin
      state_d   = S_EXC;
      exccode_d = EXC_INT;
      epcsrc_d  = 1'b0;
      irq_id_d  = irq_win;
    end

    if (reset) begin
      bus.wpc  = 1'b0;
      bus.wir  = 1'b0;
      bus.wmem = 1'b0;
      bus.wreg = 1'b0;
      bus.wsta = 1'b0;
      bus.wcau = 1'b0;
      bus.wepc = 1'b0;
      bus.exc  = 1'b0;
      bus.inta = 1'b0;
    end
  end

  assign bus.state   = state_q;
  assign bus.irq_id  = irq_id_q;
  assign bus.exccode = exccode_q;
  assign bus.epcsrc  = epcsrc_q;

  // state register and latched exception cause
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IF;
      irq_id_q  <= '0;
      exccode_q <= EXC_INT;
      epcsrc_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      irq_id_q  <= irq_id_d;
      exccode_q <= exccode_d;
      epcsrc_q  <= epcsrc_d;
    end
  end

endmodule

// File: tb/tb_mccu_exc.sv
// Scoreboard bench for mccu_exc: each cycle queues the expected control
// values, and they are popped and compared at the following negedge.
module tb_mccu_exc;

  localparam int NI = 4;
  localparam int IW = 2;

  logic clock = 1'b0;
  logic reset;

  mccu_exc_if #(.NUM_IRQ(NI), .IRQ_IDW(IW)) bus ();

  mccu_exc #(.NUM_IRQ(NI), .IRQ_IDW(IW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef enum int {
    O_STATE, O_WPC, O_WIR, O_WREG, O_WMEM, O_EXC, O_INTA, O_CODE, O_EPCSRC,
    O_STAOP, O_SELPC, O_IRQID, O_WSTA, O_WCAU, O_WEPC, O_MFC0, O_REGRT, O_M2REG, O_IORD
  } obs_e;

  typedef struct {
    string       tag;
    obs_e        sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic logic [31:0] observe(input obs_e s);
    case (s)
      O_STATE:  return 32'(bus.state);
      O_WPC:    return 32'(bus.wpc);
      O_WIR:    return 32'(bus.wir);
      O_WREG:   return 32'(bus.wreg);
      O_WMEM:   return 32'(bus.wmem);
      O_EXC:    return 32'(bus.exc);
      O_INTA:   return 32'(bus.inta);
      O_CODE:   return 32'(bus.exccode);
      O_EPCSRC: return 32'(bus.epcsrc);
      O_STAOP:  return 32'(bus.sta_op);
      O_SELPC:  return 32'(bus.selpc);
      O_IRQID:  return 32'(bus.irq_id);
      O_WSTA:   return 32'(bus.wsta);
      O_WCAU:   return 32'(bus.wcau);
      O_WEPC:   return 32'(bus.wepc);
      O_MFC0:   return 32'(bus.mfc0);
      O_REGRT:  return 32'(bus.regrt);
      O_M2REG:  return 32'(bus.m2reg);
      O_IORD:   return 32'(bus.iord);
      default:  return '0;
    endcase
  endfunction

  task automatic want(input string tag, input obs_e s, input int unsigned v);
    sb.push_back('{tag, s, 32'(v)});
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clock);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, observe(e.sel), e.val);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rd);
    bus.op   = op;
    bus.func = fn;
    bus.rs   = rs;
    bus.rd   = rd;
  endtask

  task automatic run_if(input string nm);
    bus.mem_ready = 1'b1;
    want({nm, "_if_state"}, O_STATE, 0);
    want({nm, "_if_wir"}, O_WIR, 1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors so far", n_vec);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    bus.intr = '0;
    bus.sta  = '0;
    bus.z = 1'b0;
    bus.v = 1'b0;
    instr(6'b000000, 6'b100000, 5'd1, 5'd3);  // add

    // reset state
    want("rst_state", O_STATE, 0); want("rst_wpc", O_WPC, 0);
    want("rst_wir", O_WIR, 0);     want("rst_exc", O_EXC, 0);
    want("rst_inta", O_INTA, 0);
    tick();
    reset = 1'b0;

    // IF memory wait
    bus.mem_ready = 1'b0;
    want("ifwait1_state", O_STATE, 0); want("ifwait1_wir", O_WIR, 0); tick();
    want("ifwait2_state", O_STATE, 0); want("ifwait2_wir", O_WIR, 0); tick();
    bus.mem_ready = 1'b1;
    want("ifgo_wir", O_WIR, 1); want("ifgo_wpc", O_WPC, 1); tick();

    // add, interrupt line 1 pending at WB
    want("add_id_state", O_STATE, 1); tick();
    want("add_exe_state", O_STATE, 2); tick();
    bus.sta  = 5'b00101;
    bus.intr = 4'b0110;
    want("add_wb_state", O_STATE, 4); want("add_wb_wreg", O_WREG, 1); want("add_wb_regrt", O_REGRT, 0);
    tick();
    bus.sta  = '0;
    bus.intr = '0;
    want("irq_state", O_STATE, 5);  want("irq_exc", O_EXC, 1);     want("irq_id", O_IRQID, 1);
    want("irq_inta", O_INTA, 1);    want("irq_epcsrc", O_EPCSRC, 0); want("irq_staop", O_STAOP, 1);
    want("irq_code", O_CODE, 0);    want("irq_selpc", O_SELPC, 2);   want("irq_wepc", O_WEPC, 1);
    want("irq_wcau", O_WCAU, 1);
    tick();

    // addi with overflow
    instr(6'b001000, 6'b000000, 5'd2, 5'd0);
    run_if("addi");
    want("addi_id_state", O_STATE, 1); tick();
    bus.v = 1'b1;
    want("addi_exe_state", O_STATE, 2); want("addi_exe_wreg", O_WREG, 0); tick();
    bus.v = 1'b0;
`ifdef MCCU_OVF_TRAP_EN
    want("ovf_state", O_STATE, 5); want("ovf_code", O_CODE, 12); want("ovf_epcsrc", O_EPCSRC, 1);
    want("ovf_wreg", O_WREG, 0);   want("ovf_inta", O_INTA, 0);
    tick();
`else
    want("addi_wb_state", O_STATE, 4); want("addi_wb_wreg", O_WREG, 1); want("addi_wb_regrt", O_REGRT, 1);
    tick();
`endif

    // syscall then eret
    instr(6'b000000, 6'b001100, 5'd0, 5'd0);
    run_if("sys");
    want("sys_id_state", O_STATE, 1); want("sys_id_wreg", O_WREG, 0); tick();
    want("sys_state", O_STATE, 5); want("sys_code", O_CODE, 8); want("sys_epcsrc", O_EPCSRC, 1);
    want("sys_inta", O_INTA, 0);   want("sys_exc", O_EXC, 1);
    tick();
    instr(6'b010000, 6'b011000, 5'b10000, 5'd0);
    run_if("eret");
    want("eret_state", O_STATE, 1); want("eret_selpc", O_SELPC, 1); want("eret_staop", O_STAOP, 2);
    want("eret_wpc", O_WPC, 1);     want("eret_wsta", O_WSTA, 1);
    tick();

    // mtc0 EPC, then mfc0 cause
    instr(6'b010000, 6'b000000, 5'b00100, 5'd14);
    run_if("mtc0");
    want("mtc0_state", O_STATE, 1); want("mtc0_wepc", O_WEPC, 1);
    want("mtc0_wsta", O_WSTA, 0);   want("mtc0_wcau", O_WCAU, 0);
    tick();
    instr(6'b010000, 6'b000000, 5'b00000, 5'd13);
    run_if("mfc0");
    want("mfc0_id_state", O_STATE, 1); tick();
    want("mfc0_wb_state", O_STATE, 4); want("mfc0_sel", O_MFC0, 2);
    want("mfc0_regrt", O_REGRT, 1);    want("mfc0_wreg", O_WREG, 1);
    tick();

    // reserved opcode
    instr(6'b111111, 6'b000000, 5'd0, 5'd0);
    run_if("ri");
    want("ri_id_state", O_STATE, 1); tick();
    want("ri_state", O_STATE, 5); want("ri_code", O_CODE, 10); want("ri_epcsrc", O_EPCSRC, 1);
    tick();

    // lw with a memory wait
    instr(6'b100011, 6'b000000, 5'd1, 5'd0);
    run_if("lw");
    want("lw_id_state", O_STATE, 1); tick();
    want("lw_exe_state", O_STATE, 2); tick();
    bus.mem_ready = 1'b0;
    want("lw_memw_state", O_STATE, 3); want("lw_memw_iord", O_IORD, 1); tick();
    bus.mem_ready = 1'b1;
    want("lw_mem_state", O_STATE, 3); tick();
    want("lw_wb_state", O_STATE, 4); want("lw_wb_m2reg", O_M2REG, 1); want("lw_wb_regrt", O_REGRT, 1);
    tick();

    // sw with a memory wait
    instr(6'b101011, 6'b000000, 5'd1, 5'd0);
    run_if("sw");
    want("sw_id_state", O_STATE, 1); tick();
    want("sw_exe_state", O_STATE, 2); tick();
    bus.mem_ready = 1'b0;
    want("sw_memw_state", O_STATE, 3); want("sw_memw_wmem", O_WMEM, 0); tick();
    bus.mem_ready = 1'b1;
    want("sw_mem_wmem", O_WMEM, 1); tick();

    // beq taken with lines pending but IE clear: no interrupt
    instr(6'b000100, 6'b000000, 5'd1, 5'd0);
    run_if("beq1");
    want("beq1_id_state", O_STATE, 1); tick();
    bus.z = 1'b1; bus.sta = 5'b11110; bus.intr = 4'b1111;
    want("beq1_exe_wpc", O_WPC, 1); tick();
    want("beq1_noirq_state", O_STATE, 0); tick();   // IF fetch, IR still holds beq
    want("beq2_id_state", O_STATE, 1); tick();
    bus.sta = 5'b11111;
    want("beq2_exe_state", O_STATE, 2); tick();
    bus.sta = '0; bus.intr = '0; bus.z = 1'b0;
    want("prio_state", O_STATE, 5); want("prio_id", O_IRQID, 0); want("prio_inta", O_INTA, 1);
    tick();

    // reset held three cycles in the middle of EXE
    instr(6'b000000, 6'b100000, 5'd1, 5'd3);
    run_if("rmid");
    want("rmid_id_state", O_STATE, 1); tick();
    want("rmid_exe_state", O_STATE, 2); tick();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      want("rmid_rst_state", O_STATE, 0); want("rmid_rst_wpc", O_WPC, 0);
      want("rmid_rst_wreg", O_WREG, 0);   want("rmid_rst_wepc", O_WEPC, 0);
      tick();
    end
    reset = 1'b0;
    want("rmid_rel_state", O_STATE, 0); want("rmid_rel_wpc", O_WPC, 1); tick();
    want("rmid_rel_id", O_STATE, 1); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
